// File: rtl/apb_cmd_master_pkg.sv
// Shared types and constants for the byte-stream to APB command master.
package apb_cmd_pkg;

    // Controller states, exposed on the debug port as well.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WDATA  = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        RESP   = 3'd4
    } state_t;

    // Header byte layout: bit7 = write flag, bits4:0 = register address.
    localparam int HDR_W_BIT    = 7;
    localparam int HDR_ADDR_MSB = 4;

    // Read data returned when a read is aborted by the timeout.
    localparam logic [7:0] ERR_RDATA = 8'hFF;

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command stream, response stream and APB requester signals of the command master.
//
// Handshake rule for both byte streams: a byte moves on a rising PCLK edge
// where VALID and READY are both high; the sender holds DATA stable while
// VALID is high and the receiver has not yet taken it.
interface apb_cmd_master_if;
    // Command byte stream (host deserializer -> master)
    logic [7:0] CMD_DATA;
    logic       CMD_VALID;
    logic       CMD_READY;
    // Response byte stream (master -> host)
    logic [7:0] RSP_DATA;
    logic       RSP_VALID;
    logic       RSP_READY;
    // APB requester (master -> debugger register block)
    logic       PSEL;
    logic [4:0] PADDR;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;

    // The command master side.
    modport master (
        input  CMD_DATA, CMD_VALID,
        output CMD_READY,
        output RSP_DATA, RSP_VALID,
        input  RSP_READY,
        output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY
    );

    // The environment side: command source, response sink and APB responder.
    modport slave (
        output CMD_DATA, CMD_VALID,
        input  CMD_READY,
        input  RSP_DATA, RSP_VALID,
        output RSP_READY,
        input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_cmd_master.sv
// Byte-stream to APB initiator: decodes header/data command bytes, runs one
// APB transfer per command with bounded wait, and returns read data as a byte.
module apb_cmd_master
    import apb_cmd_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    apb_cmd_master_if.master bus,
    output logic             BUSY,
    output logic             ERR,
    output state_t           dbg_state
);

    // A zero TIMEOUT disables the bound; keep the counter at least one bit wide.
    localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    state_t        state_q, state_d;
    logic [4:0]    paddr_q, paddr_d;
    logic          pwrite_q, pwrite_d;
    logic [7:0]    pwdata_q, pwdata_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          timed_out;

    assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            paddr_q    <= '0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            rsp_data_q <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            paddr_q    <= paddr_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            rsp_data_q <= rsp_data_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    // Next-state, command decode, wait/timeout handling and response capture.
    always_comb begin
        state_d    = state_q;
        paddr_d    = paddr_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        rsp_data_d = rsp_data_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.CMD_VALID) begin
                    paddr_d  = bus.CMD_DATA[HDR_ADDR_MSB:0];
                    pwrite_d = bus.CMD_DATA[HDR_W_BIT];
                    state_d  = bus.CMD_DATA[HDR_W_BIT] ? WDATA : SETUP;
                end
            end
            WDATA: begin
                if (bus.CMD_VALID) begin
                    pwdata_d = bus.CMD_DATA;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                // Completion takes priority over a timeout in the same cycle.
                if (bus.PREADY) begin
                    if (!pwrite_q) begin
                        rsp_data_d = bus.PRDATA;
                        state_d    = RESP;
                    end else begin
                        state_d    = IDLE;
                    end
                end else if (timed_out) begin
                    err_d = 1'b1;
                    if (!pwrite_q) begin
                        rsp_data_d = ERR_RDATA;
                        state_d    = RESP;
                    end else begin
                        state_d    = IDLE;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.RSP_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; CMD_READY is forced low while reset is asserted.
    assign bus.CMD_READY = PRESETn && ((state_q == IDLE) || (state_q == WDATA));
    assign bus.RSP_VALID = (state_q == RESP);
    assign bus.RSP_DATA  = rsp_data_q;
    assign bus.PSEL      = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.PENABLE   = (state_q == ACCESS);
    assign bus.PADDR     = paddr_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_q;
    assign BUSY          = (state_q != IDLE);
    assign ERR           = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a configurable APB responder model.
module tb_apb_cmd_master;
    import apb_cmd_pkg::*;

    logic   PCLK = 1'b0;
    logic   PRESETn = 1'b0;
    logic   BUSY;
    logic   ERR;
    state_t dbg_state;

    int tests = 0;
    int fails = 0;

    // Responder configuration
    int         waits_cfg = 0;
    logic       stuck = 1'b0;
    logic [7:0] rdata_cfg = 8'h00;
    int         acc_cnt = 0;

    apb_cmd_master_if bus();

    apb_cmd_master #(.TIMEOUT(4)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .bus       (bus),
        .BUSY      (BUSY),
        .ERR       (ERR),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 PCLK = ~PCLK;

    // Responder: raises PREADY after waits_cfg low ACCESS cycles unless stuck.
    assign bus.PREADY = bus.PSEL && bus.PENABLE && !stuck && (acc_cnt == waits_cfg);
    assign bus.PRDATA = rdata_cfg;

    always @(posedge PCLK) begin
        if (bus.PSEL && bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 1;
        else if (!bus.PENABLE) acc_cnt <= 0;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver: present a byte at a negedge, wait (bounded) for acceptance.
    task automatic send_byte(input logic [7:0] b, output int waited);
        waited = 0;
        bus.CMD_DATA  = b;
        bus.CMD_VALID = 1'b1;
        while (!bus.CMD_READY && waited < 50) begin
            @(negedge PCLK);
            waited++;
        end
        tests++;
        if (!bus.CMD_READY) begin
            fails++;
            $display("FAIL cmd_accept: byte %h got ready 0, expected 1", b);
        end
        @(posedge PCLK);
        #1 bus.CMD_VALID = 1'b0;
    endtask

    // Driver: take one response byte (call at a negedge with RSP_VALID high).
    task automatic take_rsp();
        bus.RSP_READY = 1'b1;
        @(posedge PCLK);
        #1 bus.RSP_READY = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        bus.CMD_VALID = 1'b0;
        bus.CMD_DATA  = 8'h00;
        bus.RSP_READY = 1'b0;
        repeat (2) @(negedge PCLK);
        tests++;
        if ({bus.CMD_READY, bus.RSP_VALID, bus.PSEL, bus.PENABLE, bus.PWRITE, BUSY, ERR} !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b, expected 0000000",
                     {bus.CMD_READY, bus.RSP_VALID, bus.PSEL, bus.PENABLE, bus.PWRITE, BUSY, ERR});
        end
        tests++;
        if ({bus.PADDR, bus.PWDATA, bus.RSP_DATA} !== 21'h0) begin
            fails++;
            $display("FAIL reset_data: got %h, expected 0", {bus.PADDR, bus.PWDATA, bus.RSP_DATA});
        end
        tests++;
        if (dbg_state !== IDLE) begin
            fails++;
            $display("FAIL reset_state: got %0d, expected %0d", dbg_state, IDLE);
        end
        PRESETn = 1'b1;
        @(negedge PCLK);
        tests++;
        if ({bus.CMD_READY, BUSY} !== 2'b10) begin
            fails++;
            $display("FAIL reset_release: got ready/busy %b, expected 10", {bus.CMD_READY, BUSY});
        end
    endtask

    task automatic test_read_basic();
        int w;
        waits_cfg = 0; stuck = 1'b0; rdata_cfg = 8'h3C;
        send_byte(8'h01, w);
        @(negedge PCLK);  // cycle 1: SETUP
        tests++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR} !== {3'b100, 5'h01}) begin
            fails++;
            $display("FAIL rd_setup: got %b, expected 10000001", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR});
        end
        @(negedge PCLK);  // cycle 2: ACCESS
        tests++;
        if ({bus.PSEL, bus.PENABLE, bus.RSP_VALID} !== 3'b110) begin
            fails++;
            $display("FAIL rd_access: got %b, expected 110", {bus.PSEL, bus.PENABLE, bus.RSP_VALID});
        end
        @(negedge PCLK);  // cycle 3: RESP
        tests++;
        if ({bus.RSP_VALID, bus.PSEL, ERR, bus.RSP_DATA} !== {3'b100, 8'h3C}) begin
            fails++;
            $display("FAIL rd_resp: got %b %h, expected 100 3c", {bus.RSP_VALID, bus.PSEL, ERR}, bus.RSP_DATA);
        end
        take_rsp();
        @(negedge PCLK);
        tests++;
        if ({bus.CMD_READY, bus.RSP_VALID, BUSY} !== 3'b100) begin
            fails++;
            $display("FAIL rd_done: got %b, expected 100", {bus.CMD_READY, bus.RSP_VALID, BUSY});
        end
    endtask

    task automatic test_write_wait();
        int w;
        waits_cfg = 2; stuck = 1'b0;
        send_byte(8'h85, w);
        @(negedge PCLK);
        tests++;
        if ({bus.CMD_READY, BUSY, bus.PSEL} !== 3'b110) begin
            fails++;
            $display("FAIL wr_wdata: got %b, expected 110", {bus.CMD_READY, BUSY, bus.PSEL});
        end
        send_byte(8'hA7, w);
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            tests++;
            if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.RSP_VALID, bus.CMD_READY}
                !== {1'b1, (i != 0), 1'b1, 5'h05, 8'hA7, 2'b00}) begin
                fails++;
                $display("FAIL wr_cycle%0d: got psel/pen/pwr %b addr %h data %h rv/cr %b, expected 1%b1 05 a7 00",
                         i, {bus.PSEL, bus.PENABLE, bus.PWRITE}, bus.PADDR, bus.PWDATA,
                         {bus.RSP_VALID, bus.CMD_READY}, (i != 0));
            end
        end
        @(negedge PCLK);
        tests++;
        if ({bus.PSEL, BUSY, bus.CMD_READY, bus.RSP_VALID, ERR} !== 5'b00100) begin
            fails++;
            $display("FAIL wr_done: got %b, expected 00100", {bus.PSEL, BUSY, bus.CMD_READY, bus.RSP_VALID, ERR});
        end
    endtask

    task automatic test_timeout();
        int w;
        stuck = 1'b1;
        send_byte(8'h0A, w);
        @(negedge PCLK);
        tests++;
        if ({bus.PSEL, bus.PENABLE} !== 2'b10) begin
            fails++;
            $display("FAIL to_setup: got %b, expected 10", {bus.PSEL, bus.PENABLE});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            tests++;
            if ({bus.PSEL, bus.PENABLE, ERR, bus.RSP_VALID} !== 4'b1100) begin
                fails++;
                $display("FAIL to_access%0d: got %b, expected 1100", i, {bus.PSEL, bus.PENABLE, ERR, bus.RSP_VALID});
            end
        end
        @(negedge PCLK);
        tests++;
        if ({bus.PSEL, ERR, bus.RSP_VALID, bus.RSP_DATA} !== {3'b011, 8'hFF}) begin
            fails++;
            $display("FAIL to_abort: got %b %h, expected 011 ff", {bus.PSEL, ERR, bus.RSP_VALID}, bus.RSP_DATA);
        end
        @(negedge PCLK);
        tests++;
        if ({ERR, bus.RSP_VALID} !== 2'b01) begin
            fails++;
            $display("FAIL to_err_pulse: got %b, expected 01", {ERR, bus.RSP_VALID});
        end
        take_rsp();
        stuck = 1'b0;
        @(negedge PCLK);
        tests++;
        if ({bus.CMD_READY, BUSY} !== 2'b10) begin
            fails++;
            $display("FAIL to_done: got %b, expected 10", {bus.CMD_READY, BUSY});
        end
    endtask

    task automatic test_backpressure();
        int w;
        waits_cfg = 0; rdata_cfg = 8'h5A;
        send_byte(8'h1F, w);
        repeat (3) @(negedge PCLK);
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ({bus.RSP_VALID, bus.CMD_READY, bus.RSP_DATA} !== {2'b10, 8'h5A}) begin
                fails++;
                $display("FAIL bp_hold%0d: got %b %h, expected 10 5a", i, {bus.RSP_VALID, bus.CMD_READY}, bus.RSP_DATA);
            end
            @(negedge PCLK);
        end
        take_rsp();
        @(negedge PCLK);
        tests++;
        if ({bus.RSP_VALID, bus.CMD_READY, BUSY} !== 3'b010) begin
            fails++;
            $display("FAIL bp_done: got %b, expected 010", {bus.RSP_VALID, bus.CMD_READY, BUSY});
        end
    endtask

    task automatic test_reset_mid();
        int w;
        stuck = 1'b1;
        send_byte(8'h82, w);
        send_byte(8'h11, w);
        @(negedge PCLK);  // SETUP
        @(negedge PCLK);  // ACCESS
        tests++;
        if ({bus.PSEL, bus.PENABLE} !== 2'b11) begin
            fails++;
            $display("FAIL rst_pre: got %b, expected 11", {bus.PSEL, bus.PENABLE});
        end
        PRESETn = 1'b0;
        @(negedge PCLK);
        tests++;
        if ({bus.PSEL, bus.PENABLE, ERR, bus.CMD_READY, BUSY} !== 5'b00000) begin
            fails++;
            $display("FAIL rst_mid: got %b, expected 00000", {bus.PSEL, bus.PENABLE, ERR, bus.CMD_READY, BUSY});
        end
        PRESETn = 1'b1;
        stuck = 1'b0;
        @(negedge PCLK);
        tests++;
        if ({bus.CMD_READY, ERR} !== 2'b10) begin
            fails++;
            $display("FAIL rst_release: got %b, expected 10", {bus.CMD_READY, ERR});
        end
        rdata_cfg = 8'h77;
        send_byte(8'h00, w);
        @(negedge PCLK);
        tests++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR} !== {3'b100, 5'h00}) begin
            fails++;
            $display("FAIL rst_rd_setup: got %b, expected 10000000", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR});
        end
        repeat (2) @(negedge PCLK);
        tests++;
        if ({bus.RSP_VALID, ERR, bus.RSP_DATA} !== {2'b10, 8'h77}) begin
            fails++;
            $display("FAIL rst_rd_resp: got %b %h, expected 10 77", {bus.RSP_VALID, ERR}, bus.RSP_DATA);
        end
        take_rsp();
        @(negedge PCLK);
    endtask

    task automatic test_back_to_back();
        int w;
        waits_cfg = 0; rdata_cfg = 8'hC1;
        send_byte(8'hE3, w);
        send_byte(8'h44, w);
        @(negedge PCLK);
        tests++;
        if ({bus.PSEL, bus.PWRITE, bus.PADDR, bus.PWDATA} !== {2'b11, 5'h03, 8'h44}) begin
            fails++;
            $display("FAIL rsvd_hdr: got psel/pwr %b addr %h data %h, expected 11 03 44",
                     {bus.PSEL, bus.PWRITE}, bus.PADDR, bus.PWDATA);
        end
        @(negedge PCLK);  // ACCESS
        @(negedge PCLK);  // first IDLE cycle
        send_byte(8'h07, w);
        tests++;
        if (w !== 0) begin
            fails++;
            $display("FAIL b2b_accept: got %0d wait cycles, expected 0", w);
        end
        @(negedge PCLK);
        tests++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR} !== {3'b100, 5'h07}) begin
            fails++;
            $display("FAIL b2b_setup: got %b, expected 10000111", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR});
        end
        repeat (2) @(negedge PCLK);
        tests++;
        if ({bus.RSP_VALID, bus.RSP_DATA} !== {1'b1, 8'hC1}) begin
            fails++;
            $display("FAIL b2b_resp: got %b %h, expected 1 c1", bus.RSP_VALID, bus.RSP_DATA);
        end
        take_rsp();
        @(negedge PCLK);
    endtask

    initial begin
        bus.CMD_VALID = 1'b0;
        bus.CMD_DATA  = 8'h00;
        bus.RSP_READY = 1'b0;
        test_reset();
        test_read_basic();
        test_write_wait();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
